// File: rtl/vga_pkg.sv
// Shared definitions for the asynchronous write capture block:
// default widths/depth and the consumer-side FIFO state encoding.
package vga_pkg;

    localparam int ADDR_W_DEF = 11;
    localparam int DATA_W_DEF = 8;
    localparam int DEPTH_DEF  = 4;

    typedef enum logic {
        EMPTY    = 1'b0,
        NONEMPTY = 1'b1
    } fifo_state_e;

endpackage

// File: rtl/cmd_fifo.sv
// Command FIFO with registered valid (EMPTY/NONEMPTY FSM) and sticky overflow.
// Ports: clk_i, rst_i (async high), push_i/din_i write side,
//        valid_o/ready_i/dout_o read side, overflow_o sticky drop flag.
module cmd_fifo
    import vga_pkg::*;
#(
    parameter int WIDTH = ADDR_W_DEF + DATA_W_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             ready_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] dout_o,
    output logic             overflow_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;
    fifo_state_e      state_q;
    logic             overflow_q;

    logic pop;
    logic full;
    logic wr_en;
    logic drop;

    assign pop   = (state_q == NONEMPTY) & ready_i;
    assign full  = (count_q == CW'(DEPTH));
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign wr_en = push_i & (~full | pop);
    assign drop  = push_i & full & ~pop;

    always_comb begin
        count_d = count_q;
        case ({wr_en, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            state_q    <= EMPTY;
        end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)   rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
            if (drop) overflow_q <= 1'b1;
            case (state_q)
                EMPTY: begin
                    if (wr_en) state_q <= NONEMPTY;
                end
                NONEMPTY: begin
                    if (pop && !wr_en && count_q == CW'(1))
                        state_q <= EMPTY;
                end
                default: state_q <= EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en) mem_q[wr_ptr_q] <= din_i;
    end

    assign valid_o    = (state_q == NONEMPTY);
    assign dout_o     = valid_o ? mem_q[rd_ptr_q] : '0;
    assign overflow_o = overflow_q;

endmodule

// File: rtl/async_write_sync.sv
// Captures writes signalled by an asynchronous strobe into a command FIFO.
// Ports: clk_50, reset (async high), wr_strobe/wr_addr/wr_data async write,
//        out_valid/out_ready/out_addr/out_data FIFO head, overflow sticky.
// Option: define ASYNC_WRITE_GLITCH_FILTER_EN to require two synced high cycles.
module async_write_sync
    import vga_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic              clk_50,
    input  logic              reset,
    input  logic              wr_strobe,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic [DATA_W-1:0] out_data,
    output logic              overflow
);

`ifdef ASYNC_WRITE_GLITCH_FILTER_EN
    localparam logic [1:0] INIT = 2'd3;
`else
    localparam logic [1:0] INIT = 2'd2;
`endif

    logic       s1_q;
    logic       s2_q;
    logic       s3_q;
    logic [1:0] init_q;
    logic       det;

`ifdef ASYNC_WRITE_GLITCH_FILTER_EN
    logic s2d_q;
`endif

    // s3 is held high until the sync chain has seen the strobe level
    // present at reset release, so an already-high strobe is not a write.
    always_ff @(posedge clk_50 or posedge reset) begin
        if (reset) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            s3_q   <= 1'b0;
            init_q <= INIT;
`ifdef ASYNC_WRITE_GLITCH_FILTER_EN
            s2d_q  <= 1'b0;
`endif
        end else begin
            s1_q <= wr_strobe;
            s2_q <= s1_q;
`ifdef ASYNC_WRITE_GLITCH_FILTER_EN
            s2d_q <= s2_q;
            s3_q  <= (init_q != 2'd0) | s2d_q;
`else
            s3_q  <= (init_q != 2'd0) | s2_q;
`endif
            if (init_q != 2'd0) init_q <= init_q - 2'd1;
        end
    end

`ifdef ASYNC_WRITE_GLITCH_FILTER_EN
    assign det = s2_q & s2d_q & ~s3_q;
`else
    assign det = s2_q & ~s3_q;
`endif

    logic [ADDR_W+DATA_W-1:0] head;

    // Address/data are stable while the strobe is high, so they are
    // sampled straight from the pins in the detection cycle.
    cmd_fifo #(
        .WIDTH (ADDR_W + DATA_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i      (clk_50),
        .rst_i      (reset),
        .push_i     (det),
        .din_i      ({wr_addr, wr_data}),
        .ready_i    (out_ready),
        .valid_o    (out_valid),
        .dout_o     (head),
        .overflow_o (overflow)
    );

    assign out_addr = head[ADDR_W+DATA_W-1:DATA_W];
    assign out_data = head[DATA_W-1:0];

endmodule

// File: tb/tb_async_write_sync.sv
// Directed bench for async_write_sync: table of single writes plus
// hand-written sequences for latency, full FIFO, reset and glitches.
module tb_async_write_sync;

    logic        clk;
    logic        reset;
    logic        wr_strobe;
    logic [10:0] wr_addr;
    logic [7:0]  wr_data;
    logic        out_valid;
    logic        out_ready;
    logic [10:0] out_addr;
    logic [7:0]  out_data;
    logic        overflow;

    int applied = 0;
    int errs    = 0;

`ifdef ASYNC_WRITE_GLITCH_FILTER_EN
    localparam int LAT       = 4;
    localparam int DET_EDGES = 3;
`else
    localparam int LAT       = 3;
    localparam int DET_EDGES = 2;
`endif

    typedef struct {
        logic [10:0] a;
        logic [7:0]  d;
        int          hi;
        logic [10:0] ea;
        logic [7:0]  ed;
    } vec_t;

    vec_t tbl[6];
    logic [18:0] got[$];
    logic [18:0] exp_q[$];

    async_write_sync #(
        .ADDR_W (11),
        .DATA_W (8),
        .DEPTH  (4)
    ) dut (
        .clk_50    (clk),
        .reset     (reset),
        .wr_strobe (wr_strobe),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_addr  (out_addr),
        .out_data  (out_data),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Record every head accepted by the consumer.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready)
            got.push_back({out_addr, out_data});
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        applied++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic write(logic [10:0] a, logic [7:0] d, int hi);
        @(posedge clk);
        #5;
        wr_addr   = a;
        wr_data   = d;
        wr_strobe = 1'b1;
        repeat (hi) @(posedge clk);
        #3;
        wr_strobe = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        got.delete();
        repeat (3) @(posedge clk);
    endtask

    task automatic expect_got(string name);
        check({name, "_n"}, got.size(), exp_q.size());
        foreach (exp_q[i]) begin
            check(name, (i < got.size()) ? got[i] : 19'bx, exp_q[i]);
        end
    endtask

    initial begin
        int  n;
        bit  found;
        bit  seen;

        tbl[0] = '{11'h555, 8'h5A, 3,  11'h555, 8'h5A};
        tbl[1] = '{11'h2AA, 8'hA5, 4,  11'h2AA, 8'hA5};
        tbl[2] = '{11'h7FF, 8'hFF, 3,  11'h7FF, 8'hFF};
        tbl[3] = '{11'h000, 8'h01, 5,  11'h000, 8'h01};
        tbl[4] = '{11'h401, 8'h80, 25, 11'h401, 8'h80};
        tbl[5] = '{11'h0F0, 8'h3C, 3,  11'h0F0, 8'h3C};

        reset     = 1'b1;
        wr_strobe = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        out_ready = 1'b0;

        #5;
        check("rst_valid", out_valid, 0);
        check("rst_addr", out_addr, 0);
        check("rst_data", out_data, 0);
        check("rst_ovf", overflow, 0);

        // Single write: strobe 115 ns after release, latency in edges.
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #115;
        wr_addr   = 11'h123;
        wr_data   = 8'hA5;
        out_ready = 1'b1;
        wr_strobe = 1'b1;
        n = 0;
        found = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(posedge clk);
            #1;
            n++;
            if (out_valid) found = 1;
        end
        check("latency", n, LAT);
        @(posedge clk);
        #1;
        check("one_cycle", out_valid, 0);
        #60;
        wr_strobe = 1'b0;
        repeat (4) @(posedge clk);
        exp_q = '{{11'h123, 8'hA5}};
        expect_got("single");
        got.delete();

        // Table of single writes, consumer always ready.
        foreach (tbl[i]) begin
            write(tbl[i].a, tbl[i].d, tbl[i].hi);
            repeat (6) @(posedge clk);
            exp_q = '{{tbl[i].ea, tbl[i].ed}};
            expect_got($sformatf("vec%0d", i));
            got.delete();
        end

        // Five writes into a 4-deep FIFO with no consumer.
        out_ready = 1'b0;
        do_reset();
        for (int i = 1; i <= 5; i++)
            write(11'(i), 8'(8'h10 + i), 3);
        repeat (4) @(posedge clk);
        #1;
        check("full_ovf", overflow, 1);
        check("full_head", out_addr, 11'h001);
        repeat (3) @(posedge clk);
        #1;
        check("hold_addr", out_addr, 11'h001);
        check("hold_data", out_data, 8'h11);
        #1;
        out_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        exp_q = '{{11'h001, 8'h11}, {11'h002, 8'h12},
                  {11'h003, 8'h13}, {11'h004, 8'h14}};
        expect_got("drain");
        check("ovf_sticky", overflow, 1);
        check("drain_empty", out_valid, 0);

        // Push and pop on the same edge while full.
        out_ready = 1'b0;
        do_reset();
        check("ovf_clr", overflow, 0);
        for (int i = 1; i <= 4; i++)
            write(11'(i), 8'(8'h10 + i), 3);
        @(posedge clk);
        #5;
        wr_addr   = 11'h006;
        wr_data   = 8'h16;
        wr_strobe = 1'b1;
        repeat (DET_EDGES) @(posedge clk);
        #2;
        out_ready = 1'b1;
        @(posedge clk);
        #2;
        out_ready = 1'b0;
        wr_strobe = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("pp_ovf", overflow, 0);
        check("pp_head", out_addr, 11'h002);
        out_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        exp_q = '{{11'h001, 8'h11}, {11'h002, 8'h12},
                  {11'h003, 8'h13}, {11'h004, 8'h14},
                  {11'h006, 8'h16}};
        expect_got("pp");

        // Reset during a transfer; strobe still high at release.
        do_reset();
        out_ready = 1'b1;
        @(posedge clk);
        #5;
        wr_addr   = 11'h3C3;
        wr_data   = 8'h5C;
        wr_strobe = 1'b1;
        repeat (DET_EDGES) @(posedge clk);
        #12;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen = 1;
            if (i == 10) wr_strobe = 1'b0;
        end
        check("rst_mid_valid", seen, 0);
        check("rst_mid_lost", got.size(), 0);
        write(11'h0F1, 8'h0E, 3);
        repeat (6) @(posedge clk);
        exp_q = '{{11'h0F1, 8'h0E}};
        expect_got("after_rst");
        got.delete();

`ifdef ASYNC_WRITE_GLITCH_FILTER_EN
        @(posedge clk);
        #5;
        wr_addr   = 11'h055;
        wr_data   = 8'h55;
        wr_strobe = 1'b1;
        #15;
        wr_strobe = 1'b0;
        repeat (8) @(posedge clk);
        check("glitch_15", got.size(), 0);
        @(posedge clk);
        #5;
        wr_addr   = 11'h066;
        wr_data   = 8'h66;
        wr_strobe = 1'b1;
        #100;
        wr_strobe = 1'b0;
        repeat (8) @(posedge clk);
        exp_q = '{{11'h066, 8'h66}};
        expect_got("glitch_100");
        got.delete();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", applied, errs);
        $finish;
    end

endmodule
